bypass_register_file: RTL
=========================

# bypass_register_file

Parametrised multi-port register file for the RV64IF datapath, used for both the integer file (x0 hardwired to zero) and the FP file (f0 writable). It provides three combinational read ports (rs1/rs2/rs3 for fused multiply-add) and two write ports (ALU/FPU writeback and load writeback), with optional same-cycle write-to-read bypass. A per-register busy scoreboard tracks in-flight producers, so the issue stage can stall on RAW hazards.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored array only

- in_Clk  input  1  clock, all state on rising edge
- in_Rst_N  input  1  asynchronous active-low reset
- in_addr_A / in_addr_B / in_addr_C  input  ADDR_WIDTH  read addresses
- out_data_A / out_data_B / out_data_C  output  DATA_WIDTH  read data, combinational
- out_busy_A / out_busy_B / out_busy_C  output  1  scoreboard busy for the matching read address, combinational
- in_wr0_En, in_wr0_Addr [ADDR_WIDTH], in_wr0_Data [DATA_WIDTH]  input  write port 0 (execute writeback)
- in_wr1_En, in_wr1_Addr [ADDR_WIDTH], in_wr1_Data [DATA_WIDTH]  input  write port 1 (load writeback)
- in_issue_En, in_issue_Addr [ADDR_WIDTH]  input  marks the destination register busy
- out_any_busy  output  1  OR of all busy bits (pipeline drain / fence)

## Operation
- Reset (async, in_Rst_N low): all registers 0 and all busy bits 0. Outputs then read 0 data and 0 busy.
- Write: on a rising edge, if in_wrN_En is set, reg[in_wrN_Addr] <= in_wrN_Data. With ZERO_REG=1, writes to address 0 are dropped.
- Write conflict: both ports enabled to the same address → port 1 (load) wins.
- Scoreboard set: on a rising edge, in_issue_En sets busy[in_issue_Addr]. Dropped for address 0 when ZERO_REG=1.
- Scoreboard clear: any enabled write clears busy[addr].
- Issue and write to the same address in one cycle: set wins and busy stays 1, because the new producer supersedes the old one.
- Read, ZERO_REG=1 and addr 0: data 0, busy 0.
- Read, BYPASS=1: if a write is enabled to the read address this cycle, data = write data (port 1 over port 0) and busy = 0 unless a same-cycle issue targets that address. Otherwise data = array and busy = busy[addr].
- Read, BYPASS=0: data and busy come from stored state only.
- out_any_busy reflects stored busy bits only; no bypass applies.

## Timing
- Read latency 0 (combinational from address).
- Write to array: visible through the array one cycle after the enabling edge. With BYPASS=1 it is visible in the same cycle.
- Issue → busy visible on the cycle after the issue edge.
- No handshake; enables are single-cycle qualifiers sampled each edge.
- Reset asserted mid-operation clears everything immediately, regardless of clock; pending writes on that edge are lost.

## Structure
- Shared package `rf_pkg`:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - localparam NUM_REGS = 2**ADDR_WIDTH;
  - write-port index constants (WB_EXE=0, WB_LOAD=1).
- Sub-module `rf_scoreboard`: busy vector, set/clear priority, three busy lookups and out_any_busy. Parametrised by ADDR_WIDTH, ZERO_REG and BYPASS; it takes the write enables and addresses.
- Top level holds the data array, write-priority mux, bypass muxes and zero-register gating.

## Test plan
- Reset, then read all 32 addresses → data 0, busy 0, out_any_busy 0. Then write 0xDEAD to x5 and pulse in_Rst_N low between edges → x5 reads 0 immediately.
- ZERO_REG=1: wr0 writes 0x1234 to addr 0 and issue addr 0 → reads 0, busy 0. ZERO_REG=0: same stimulus → reads 0x1234 next cycle, busy 1 after issue.
- Both ports write addr 7 (wr0 = 0x1111, wr1 = 0x2222) → reg 7 = 0x2222. With BYPASS=1 and in_addr_A=7 in the same cycle → out_data_A = 0x2222.
- BYPASS=1: issue x3, next cycle busy_A(3)=1. Then wr0 x3 = 0xABCD → out_data_A = 0xABCD and busy_A = 0 in that cycle. BYPASS=0: same stimulus gives old data and busy 1 in that cycle, then new data and busy 0 next cycle.
- Issue x9 and wr1 x9 on the same edge (x9 previously busy) → busy[9] remains 1 and out_any_busy remains 1.
- Three read ports at addresses 1, 2, 31 after writes 0x1/0x2/0xFFFF_FFFF_FFFF_FFFF → all three outputs correct simultaneously, including the top address (wrap-free indexing).

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the bypassing register file and its scoreboard.
package rf_pkg;

   // Default geometry: RV64 registers, 32 architectural entries.
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

   // Write-port indices; the load port has priority on address conflicts.
   localparam int WB_EXE  = 0;
   localparam int WB_LOAD = 1;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination in flight,
// writeback retires it. Provides three busy lookups plus a global OR.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [1:0]            wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr0_addr_i,
   input  logic [ADDR_WIDTH-1:0] wr1_addr_i,
   input  logic                  issue_en_i,
   input  logic [ADDR_WIDTH-1:0] issue_addr_i,
   input  logic [ADDR_WIDTH-1:0] rd_a_addr_i,
   input  logic [ADDR_WIDTH-1:0] rd_b_addr_i,
   input  logic [ADDR_WIDTH-1:0] rd_c_addr_i,
   output logic                  busy_a_o,
   output logic                  busy_b_o,
   output logic                  busy_c_o,
   output logic                  any_busy_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Busy lookup for one read port, with same-cycle writeback/issue forwarding.
   function automatic logic lookup(input logic [ADDR_WIDTH-1:0] addr);
      logic b;
      logic wr_hit;
      wr_hit = (wr_en_i[WB_EXE]  && (wr0_addr_i == addr)) ||
               (wr_en_i[WB_LOAD] && (wr1_addr_i == addr));
      b = busy_q[addr];
      // A retiring producer frees the register now, unless a new one issues.
      if (BYPASS && wr_hit) b = issue_en_i && (issue_addr_i == addr);
      if (ZERO_REG && (addr == '0)) b = 1'b0;
      return b;
   endfunction

   // Next busy vector: writes clear, then issue sets (new producer wins).
   always_comb begin
      // NOTE: every combinational output starts from a default so no path leaves it unassigned and infers a latch.
      busy_d = busy_q;
      if (wr_en_i[WB_EXE])  busy_d[wr0_addr_i] = 1'b0;
      if (wr_en_i[WB_LOAD]) busy_d[wr1_addr_i] = 1'b0;
      if (issue_en_i)       busy_d[issue_addr_i] = 1'b1;
      if (ZERO_REG)         busy_d[0] = 1'b0;
   end

   // Busy state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (!rst_ni) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   // Read-side busy lookups and the drain indicator (stored state only).
   always_comb begin
      busy_a_o   = lookup(rd_a_addr_i);
      busy_b_o   = lookup(rd_b_addr_i);
      busy_c_o   = lookup(rd_c_addr_i);
      any_busy_o = |busy_q;
   end

endmodule : rf_scoreboard

// File: rtl/bypass_register_file.sv
// Three-read / two-write register file with optional write-to-read bypass,
// optional hardwired-zero register 0 and a RAW busy scoreboard.
module bypass_register_file
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  in_Clk,
   input  logic                  in_Rst_N,
   input  logic [ADDR_WIDTH-1:0] in_addr_A,
   input  logic [ADDR_WIDTH-1:0] in_addr_B,
   input  logic [ADDR_WIDTH-1:0] in_addr_C,
   output logic [DATA_WIDTH-1:0] out_data_A,
   output logic [DATA_WIDTH-1:0] out_data_B,
   output logic [DATA_WIDTH-1:0] out_data_C,
   output logic                  out_busy_A,
   output logic                  out_busy_B,
   output logic                  out_busy_C,
   input  logic                  in_wr0_En,
   input  logic [ADDR_WIDTH-1:0] in_wr0_Addr,
   input  logic [DATA_WIDTH-1:0] in_wr0_Data,
   input  logic                  in_wr1_En,
   input  logic [ADDR_WIDTH-1:0] in_wr1_Addr,
   input  logic [DATA_WIDTH-1:0] in_wr1_Data,
   input  logic                  in_issue_En,
   input  logic [ADDR_WIDTH-1:0] in_issue_Addr,
   output logic                  out_any_busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   // Data seen by one read port: forwarded write data, stored value, or zero.
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] data;
      data = mem_q[addr];
      if (BYPASS) begin
         if (in_wr0_En && (in_wr0_Addr == addr)) data = in_wr0_Data;
         // Load writeback is checked last so it overrides execute writeback.
         if (in_wr1_En && (in_wr1_Addr == addr)) data = in_wr1_Data;
      end
      if (ZERO_REG && (addr == '0)) data = '0;
      return data;
   endfunction

   // Next array contents: execute write, then load write (load wins).
   always_comb begin
      mem_d = mem_q;
      if (in_wr0_En) mem_d[in_wr0_Addr] = in_wr0_Data;
      if (in_wr1_En) mem_d[in_wr1_Addr] = in_wr1_Data;
      if (ZERO_REG)  mem_d[0] = '0;
   end

   // Register array storage.
   always_ff @(posedge in_Clk or negedge in_Rst_N) begin
      // NOTE: the array is reset because architectural state must read 0 after reset; this forces flops instead of SRAM.
      if (!in_Rst_N) mem_q <= '{default: '0};
      else           mem_q <= mem_d;
   end

   // Combinational read ports.
   always_comb begin
      out_data_A = read_port(in_addr_A);
      out_data_B = read_port(in_addr_B);
      out_data_C = read_port(in_addr_C);
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
   ) u_scoreboard (
      .clk_i        (in_Clk),
      .rst_ni       (in_Rst_N),
      .wr_en_i      ({in_wr1_En, in_wr0_En}),
      .wr0_addr_i   (in_wr0_Addr),
      .wr1_addr_i   (in_wr1_Addr),
      .issue_en_i   (in_issue_En),
      .issue_addr_i (in_issue_Addr),
      .rd_a_addr_i  (in_addr_A),
      .rd_b_addr_i  (in_addr_B),
      .rd_c_addr_i  (in_addr_C),
      .busy_a_o     (out_busy_A),
      .busy_b_o     (out_busy_B),
      .busy_c_o     (out_busy_C),
      .any_busy_o   (out_any_busy)
   );

endmodule : bypass_register_file
